// File: rtl/riscv_instr_encoder.sv
// riscv_instr_encoder: packs decoded RV32I fields into instruction words
// and streams them into instruction memory over a we/ack handshake.
module riscv_instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        op_class_i,
    input  logic [2:0]        funct3_i,
    input  logic              funct7b5_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [31:0]       imm_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t state_q, state_d;

    logic        i_ok, b_ok, j_ok, sh_ok, is_shift;
    logic        bad_class, bad_imm;
    logic [31:0] word;
    logic        accept, do_write, ack;

    // Range checks: upper bits must be pure sign extension.
    assign i_ok  = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign b_ok  = ~imm_i[0] & ((&imm_i[31:12]) | ~(|imm_i[31:12]));
    assign j_ok  = ~imm_i[0] & ((&imm_i[31:20]) | ~(|imm_i[31:20]));
    assign sh_ok = ~(|imm_i[31:5]);
    assign is_shift = (funct3_i[1:0] == 2'b01);

    always_comb begin
        word      = '0;
        bad_class = 1'b0;
        bad_imm   = 1'b0;
        case (op_class_i)
            3'd0: begin
                word    = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_LOAD};
                bad_imm = ~i_ok;
            end
            3'd1: begin
                word    = {imm_i[11:5], rs2_i, rs1_i, funct3_i,
                           imm_i[4:0], OPC_STORE};
                bad_imm = ~i_ok;
            end
            3'd2: begin
                word    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                           imm_i[4:1], imm_i[11], OPC_BRANCH};
                bad_imm = ~b_ok;
            end
            3'd3: begin
                word = {1'b0, funct7b5_i, 5'b00000, rs2_i, rs1_i,
                        funct3_i, rd_i, OPC_OP};
            end
            3'd4: begin
                if (is_shift) begin
                    word    = {1'b0, funct7b5_i, 5'b00000, imm_i[4:0],
                               rs1_i, funct3_i, rd_i, OPC_OPIMM};
                    bad_imm = ~sh_ok;
                end else begin
                    word    = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_OPIMM};
                    bad_imm = ~i_ok;
                end
            end
            3'd5: begin
                word    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                           rd_i, OPC_JAL};
                bad_imm = ~j_ok;
            end
            3'd6: begin
                word    = {imm_i[11:0], rs1_i, 3'b000, rd_i, OPC_JALR};
                bad_imm = ~i_ok;
            end
            default: bad_class = 1'b1;
        endcase
    end

    assign in_ready_o = (state_q == IDLE) & ~full_o;
    assign accept     = in_valid_i & in_ready_o & ~start_i;
    assign do_write   = accept & ~bad_class & ~bad_imm;
    assign ack        = (state_q == WRITE) & mem_ack_i;
    assign mem_we_o   = (state_q == WRITE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (do_write) state_d = WRITE;
            WRITE:   if (mem_ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (start_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_addr_o  <= ADDR_BASE;
            mem_wdata_o <= '0;
            count_o     <= '0;
            full_o      <= 1'b0;
            err_o       <= 1'b0;
            err_code_o  <= 2'b00;
        end else if (start_i) begin
            mem_addr_o <= ADDR_BASE;
            count_o    <= '0;
            full_o     <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= 2'b00;
        end else begin
            if (do_write) begin
                mem_wdata_o <= word;
            end
            // Pointer saturates at the last word; full_o blocks new input.
            if (ack) begin
                count_o <= count_o + CNT_ONE;
                if (mem_addr_o == ADDR_LAST) begin
                    full_o <= 1'b1;
                end else begin
                    mem_addr_o <= mem_addr_o + ADDR_ONE;
                end
            end
            if (accept & ~do_write & ~err_o) begin
                err_o      <= 1'b1;
                err_code_o <= bad_class ? 2'b01 : 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_riscv_instr_encoder.sv
// tb_riscv_instr_encoder: randomized and directed stimulus with a
// queue scoreboard against an arithmetic encoding model.
module tb_riscv_instr_encoder;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, ready;
    logic [2:0]    op_class, f3;
    logic          b5;
    logic [4:0]    rd, rs1, rs2;
    logic [31:0]   imm;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          ack;
    logic [AW:0]   count;
    logic          full, err;
    logic [1:0]    code;

    always #5 clk = ~clk;

    riscv_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .in_valid_i(in_valid), .in_ready_o(ready),
        .op_class_i(op_class), .funct3_i(f3), .funct7b5_i(b5),
        .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
        .mem_we_o(we), .mem_addr_o(addr), .mem_wdata_o(wdata),
        .mem_ack_i(ack), .count_o(count), .full_o(full),
        .err_o(err), .err_code_o(code)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   m_ptr, m_count, m_code;
    bit   m_full, m_err;
    int   ack_delay = 0;
    int   wait_cnt = 0;
    bit   ack_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference encoding from the instruction-format tables.
    function automatic void model(input int oc, input int fv, input int bv,
                                  input int rdv, input int r1, input int r2,
                                  input int si, output bit ok,
                                  output int c, output logic [31:0] w);
        ok = 1'b1;
        c  = 0;
        w  = '0;
        case (oc)
            0, 6: begin
                ok = (si >= -2048) && (si <= 2047);
                w  = ((si & 'hfff) << 20) | (r1 << 15)
                   | ((oc == 6 ? 0 : fv) << 12) | (rdv << 7)
                   | (oc == 6 ? 'h67 : 'h03);
            end
            1: begin
                ok = (si >= -2048) && (si <= 2047);
                w  = (((si >> 5) & 'h7f) << 25) | (r2 << 20) | (r1 << 15)
                   | (fv << 12) | ((si & 31) << 7) | 'h23;
            end
            2: begin
                ok = (si % 2 == 0) && (si >= -4096) && (si <= 4094);
                w  = (((si >> 12) & 1) << 31) | (((si >> 5) & 'h3f) << 25)
                   | (r2 << 20) | (r1 << 15) | (fv << 12)
                   | (((si >> 1) & 'hf) << 8) | (((si >> 11) & 1) << 7)
                   | 'h63;
            end
            3: begin
                w = (bv << 30) | (r2 << 20) | (r1 << 15) | (fv << 12)
                  | (rdv << 7) | 'h33;
            end
            4: begin
                if (fv == 1 || fv == 5) begin
                    ok = (si >= 0) && (si <= 31);
                    w  = (bv << 30) | ((si & 31) << 20);
                end else begin
                    ok = (si >= -2048) && (si <= 2047);
                    w  = (si & 'hfff) << 20;
                end
                w = w | (r1 << 15) | (fv << 12) | (rdv << 7) | 'h13;
            end
            5: begin
                ok = (si % 2 == 0) && (si >= -1048576) && (si <= 1048574);
                w  = (((si >> 20) & 1) << 31) | (((si >> 1) & 'h3ff) << 21)
                   | (((si >> 11) & 1) << 20) | (((si >> 12) & 'hff) << 12)
                   | (rdv << 7) | 'h6f;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) c = (oc == 7) ? 1 : 2;
    endfunction

    task automatic send(input int oc, input int fv, input int bv,
                        input int rdv, input int r1, input int r2,
                        input logic [31:0] immv, input bit use_k,
                        input logic [31:0] k, input bit wait_done);
        bit          ok;
        int          c;
        int          n;
        logic [31:0] w;
        model(oc, fv, bv, rdv, r1, r2, immv, ok, c, w);
        if (use_k) w = k;
        @(negedge clk);
        op_class = oc[2:0];
        f3       = fv[2:0];
        b5       = bv[0];
        rd       = rdv[4:0];
        rs1      = r1[4:0];
        rs2      = r2[4:0];
        imm      = immv;
        in_valid = 1'b1;
        n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=ready0 required=ready1");
            in_valid = 1'b0;
        end else begin
            if (ok) exp_q.push_back('{32'(m_ptr), w});
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
            if (ok) begin
                check("we_after_accept", 32'(we), 32'(1));
                check("addr_at_write", 32'(addr), 32'(m_ptr));
                if (wait_done) begin
                    n = 0;
                    while (we && n < 50) begin
                        @(negedge clk);
                        n++;
                    end
                    check("write_done", 32'(we), 32'(0));
                    m_count++;
                    if (m_ptr == (1 << AW) - 1) m_full = 1'b1;
                    else m_ptr++;
                    check("count", 32'(count), 32'(m_count));
                    check("full", 32'(full), 32'(m_full));
                    check("ptr", 32'(addr), 32'(m_ptr));
                    check("ready", 32'(ready), 32'(!m_full));
                end
            end else begin
                check("no_we_on_err", 32'(we), 32'(0));
                if (!m_err) begin
                    m_err  = 1'b1;
                    m_code = c;
                end
                check("err", 32'(err), 32'(m_err));
                check("err_code", 32'(code), 32'(m_code));
                check("count_on_err", 32'(count), 32'(m_count));
            end
        end
    endtask

    task automatic do_start(input bit use_rst);
        @(negedge clk);
        if (use_rst) rst = 1'b1;
        else start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        exp_q.delete();
        m_ptr   = 0;
        m_count = 0;
        m_full  = 1'b0;
        m_err   = 1'b0;
        m_code  = 0;
        check("clr_we", 32'(we), 32'(0));
        check("clr_addr", 32'(addr), 32'(0));
        check("clr_count", 32'(count), 32'(0));
        check("clr_full", 32'(full), 32'(0));
        check("clr_err", 32'(err), 32'(0));
        check("clr_code", 32'(code), 32'(0));
        check("clr_ready", 32'(ready), 32'(1));
    endtask

    // Memory responder with variable ack latency.
    initial begin
        ack = 1'b0;
        forever begin
            @(negedge clk);
            ack = 1'b0;
            if (we && ack_en) begin
                if (wait_cnt >= ack_delay) begin
                    ack       = 1'b1;
                    wait_cnt  = 0;
                    ack_delay = $urandom_range(0, 3);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each write handshake.
    initial begin
        bit          busy;
        logic [31:0] a0, d0;
        exp_t        e;
        busy = 1'b0;
        a0   = '0;
        d0   = '0;
        forever begin
            @(negedge clk);
            #1;
            if (we) begin
                if (!busy) begin
                    busy = 1'b1;
                    a0   = 32'(addr);
                    d0   = wdata;
                end else begin
                    check("addr_stable", 32'(addr), a0);
                    check("wdata_stable", wdata, d0);
                end
                if (ack) begin
                    busy = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write actual=%h required=none",
                                 wdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 32'(addr), e.addr);
                        check("wr_data", wdata, e.data);
                    end
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          oc, r, v;
        logic [31:0] vi;
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        op_class = '0;
        f3 = '0;
        b5 = 1'b0;
        rd = '0;
        rs1 = '0;
        rs2 = '0;
        imm = '0;
        m_ptr = 0;
        m_count = 0;
        m_code = 0;
        m_full = 1'b0;
        m_err = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_we", 32'(we), 32'(0));
        check("rst_addr", 32'(addr), 32'(0));
        check("rst_wdata", wdata, 32'h0);
        check("rst_count", 32'(count), 32'(0));
        check("rst_full", 32'(full), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_code", 32'(code), 32'(0));
        check("rst_ready", 32'(ready), 32'(1));

        send(4, 0, 0, 1, 0, 0, 32'd5, 1'b1, 32'h00500093, 1'b1);
        send(0, 2, 0, 5, 2, 0, -32'sd4, 1'b1, 32'hFFC12283, 1'b1);
        send(3, 0, 1, 3, 1, 2, 32'd0, 1'b1, 32'h402081B3, 1'b1);
        send(2, 0, 0, 0, 1, 2, -32'sd8, 1'b1, 32'hFE208CE3, 1'b1);
        repeat (3) @(negedge clk);
        check("full_hold", 32'(full), 32'(1));
        check("ready_full", 32'(ready), 32'(0));
        check("addr_no_wrap", 32'(addr), 32'(3));

        do_start(1'b0);
        ack_delay = 3;
        send(5, 0, 0, 1, 0, 0, 32'd2048, 1'b1, 32'h001000EF, 1'b1);
        send(2, 0, 0, 0, 1, 2, 32'd3, 1'b0, 32'h0, 1'b1);
        send(7, 0, 0, 0, 0, 0, 32'd0, 1'b0, 32'h0, 1'b1);
        check("code_kept", 32'(code), 32'(2));
        do_start(1'b0);

        ack_en = 1'b0;
        send(3, 0, 0, 4, 5, 6, 32'd0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        check("we_held", 32'(we), 32'(1));
        do_start(1'b0);
        send(1, 2, 0, 0, 3, 4, 32'd100, 1'b0, 32'h0, 1'b0);
        do_start(1'b1);
        ack_en = 1'b1;

        for (int it = 0; it < 200; it++) begin
            if (m_full) begin
                check("ready_when_full", 32'(ready), 32'(0));
                do_start($urandom_range(0, 3) == 0);
            end else if ($urandom_range(0, 19) == 0) begin
                do_start(1'b0);
            end
            oc = ($urandom_range(0, 15) == 0) ? 7 : int'($urandom_range(0, 6));
            r  = $urandom_range(0, 9);
            if (r < 4) v = int'($urandom_range(0, 80)) - 40;
            else if (r < 7) v = int'($urandom_range(0, 10000)) - 5000;
            else if (r < 9) v = int'($urandom_range(0, 1 << 22)) - (1 << 21);
            else v = int'($urandom);
            if ($urandom_range(0, 1) == 1) v = v & ~1;
            vi = v;
            send(oc, $urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), vi, 1'b0, 32'h0, 1'b1);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
